// File: rtl/dispatch_rename_pipe_pkg.sv
// Shared types and helpers for the rename/dispatch pipe.
// Lane bundle, id types and the prefix-count helper.
package dispatch_rename_pipe_pkg;

    localparam int P_W        = 4;
    localparam int P_NBANK    = 4;
    localparam int P_ARCH_W   = 5;
    localparam int P_TAG_W    = 6;
    localparam int P_ROBI_W   = 5;
    localparam int P_CNT_W    = 6;
    localparam int P_MAX_CKPT = 4;
    localparam int P_BANK_W   = $clog2(P_NBANK);
    localparam int P_CKPT_W   = $clog2(P_MAX_CKPT);

    typedef logic [P_BANK_W-1:0] BANK_ID_T;
    typedef logic [P_CKPT_W-1:0] CKPT_ID_T;

    typedef struct packed {
        logic                  valid;
        BANK_ID_T              bank;
        logic [P_TAG_W-1:0]    pdest;
        logic [P_TAG_W-1:0]    told;
        logic [P_TAG_W-1:0]    src1;
        logic                  src1_rdy;
        logic [P_TAG_W-1:0]    src2;
        logic                  src2_rdy;
        logic [P_ROBI_W-1:0]   rob_idx;
        CKPT_ID_T              ckpt;
        logic [31:0]           pc;
        logic                  halt;
    } DISPATCH_LANE_T;

    // Number of set bits in v strictly below position n.
    function automatic int unsigned prefix_count(
        input logic [31:0] v,
        input int unsigned n
    );
        int unsigned c;
        c = 0;
        for (int unsigned j = 0; j < 32; j++) begin
            if (j < n && v[j]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/dispatch_rename_pipe_forward.sv
// Intra-group rename forwarding for src1, src2 and told.
// Youngest earlier writer of the same arch reg supplies the tag.
module rename_forward_net
    import dispatch_rename_pipe_pkg::*;
#(
    parameter int W      = P_W,
    parameter int ARCH_W = P_ARCH_W,
    parameter int TAG_W  = P_TAG_W
) (
    input  logic [W-1:0][ARCH_W-1:0] rs1,
    input  logic [W-1:0][ARCH_W-1:0] rs2,
    input  logic [W-1:0][ARCH_W-1:0] rd,
    input  logic [W-1:0]             wr,
    input  logic [W-1:0]             uses_rs2,
    input  logic [W-1:0][TAG_W-1:0]  pdest,
    input  logic [W-1:0][TAG_W-1:0]  mt_rs1_tag,
    input  logic [W-1:0][TAG_W-1:0]  mt_rs2_tag,
    input  logic [W-1:0][TAG_W-1:0]  mt_told,
    input  logic [W-1:0]             mt_rs1_rdy,
    input  logic [W-1:0]             mt_rs2_rdy,
    output logic [W-1:0][TAG_W-1:0]  src1,
    output logic [W-1:0][TAG_W-1:0]  src2,
    output logic [W-1:0][TAG_W-1:0]  told,
    output logic [W-1:0]             src1_rdy,
    output logic [W-1:0]             src2_rdy
);

    // Map-table value, overridden by later earlier-lane writers; x0 pinned.
    always_comb begin
        src1     = mt_rs1_tag;
        src2     = mt_rs2_tag;
        told     = mt_told;
        src1_rdy = mt_rs1_rdy;
        src2_rdy = mt_rs2_rdy;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                if (j < i && wr[j]) begin
                    if (rd[j] == rs1[i]) begin
                        src1[i]     = pdest[j];
                        src1_rdy[i] = 1'b0;
                    end
                    if (rd[j] == rs2[i]) begin
                        src2[i]     = pdest[j];
                        src2_rdy[i] = 1'b0;
                    end
                    if (rd[j] == rd[i]) told[i] = pdest[j];
                end
            end
            if (rs1[i] == '0) begin
                src1[i]     = '0;
                src1_rdy[i] = 1'b1;
            end
            if (rs2[i] == '0) begin
                src2[i]     = '0;
                src2_rdy[i] = 1'b1;
            end
            if (!uses_rs2[i]) src2_rdy[i] = 1'b1;
        end
    end

endmodule

// File: rtl/dispatch_rename_pipe.sv
// Multi-lane rename/dispatch with credits, checkpoints,
// sticky halt, registered output group and flush recovery.
module dispatch_rename_pipe
    import dispatch_rename_pipe_pkg::*;
#(
    parameter int W        = P_W,
    parameter int NBANK    = P_NBANK,
    parameter int ARCH_W   = P_ARCH_W,
    parameter int TAG_W    = P_TAG_W,
    parameter int ROBI_W   = P_ROBI_W,
    parameter int CNT_W    = P_CNT_W,
    parameter int MAX_CKPT = P_MAX_CKPT,
    localparam int CW      = $clog2(W+1),
    localparam int BW      = $clog2(NBANK),
    localparam int CKW     = $clog2(MAX_CKPT),
    localparam int KW      = $clog2(MAX_CKPT+1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [CW-1:0]            in_count,
    input  logic [W-1:0][ARCH_W-1:0] in_rs1,
    input  logic [W-1:0][ARCH_W-1:0] in_rs2,
    input  logic [W-1:0][ARCH_W-1:0] in_rd,
    input  logic [W-1:0]             in_uses_rd,
    input  logic [W-1:0]             in_uses_rs2,
    input  logic [W-1:0]             in_is_branch,
    input  logic [W-1:0]             in_is_store,
    input  logic [W-1:0]             in_halt,
    input  logic [W-1:0][BW-1:0]     in_bank,
    input  logic [W-1:0][31:0]       in_pc,
    input  logic [CNT_W-1:0]         rob_free,
    input  logic [CNT_W-1:0]         fl_free,
    input  logic [CNT_W-1:0]         sq_free,
    input  logic [NBANK-1:0][CNT_W-1:0] bank_free,
    input  logic [W-1:0][ROBI_W-1:0] rob_alloc_idx,
    input  logic [W-1:0][TAG_W-1:0]  fl_tag,
    input  logic [W-1:0][TAG_W-1:0]  mt_rs1_tag,
    input  logic [W-1:0][TAG_W-1:0]  mt_rs2_tag,
    input  logic [W-1:0][TAG_W-1:0]  mt_told,
    input  logic [W-1:0]             mt_rs1_rdy,
    input  logic [W-1:0]             mt_rs2_rdy,
    input  logic [CW-1:0]            br_resolve_cnt,
    output logic [CW-1:0]            accept_count,
    output logic [W-1:0]             mt_wr_valid,
    output logic [W-1:0][ARCH_W-1:0] mt_wr_addr,
    output logic [W-1:0][TAG_W-1:0]  mt_wr_tag,
    output logic [CW-1:0]            fl_pop,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_lane_valid,
    output logic [W-1:0][BW-1:0]     out_bank,
    output logic [W-1:0][TAG_W-1:0]  out_pdest,
    output logic [W-1:0][TAG_W-1:0]  out_told,
    output logic [W-1:0][TAG_W-1:0]  out_src1,
    output logic [W-1:0][TAG_W-1:0]  out_src2,
    output logic [W-1:0]             out_src1_rdy,
    output logic [W-1:0]             out_src2_rdy,
    output logic [W-1:0][ROBI_W-1:0] out_rob_idx,
    output logic [W-1:0][CKW-1:0]    out_ckpt,
    output logic [W-1:0][31:0]       out_pc,
    output logic [W-1:0]             out_halt,
    output logic [KW-1:0]            ckpt_inflight
);

    DISPATCH_LANE_T [W-1:0]    lane_q;
    DISPATCH_LANE_T [W-1:0]    lane_d;
    logic                      valid_q;
    logic                      halt_seen;
    CKPT_ID_T                  ckpt_ptr;
    logic [KW-1:0]             inflight_q;
    logic [KW-1:0]             inflight_d;
    int                        inflight_raw;
    logic                      can_take;
    logic [W-1:0]              wr;
    logic [W-1:0]              acc;
    logic [W-1:0]              acc_br;
    logic [W-1:0][TAG_W-1:0]   pdest;
    logic [W-1:0][TAG_W-1:0]   f_src1;
    logic [W-1:0][TAG_W-1:0]   f_src2;
    logic [W-1:0][TAG_W-1:0]   f_told;
    logic [W-1:0]              f_src1_rdy;
    logic [W-1:0]              f_src2_rdy;
    int unsigned               br_acc;

    assign can_take = !valid_q || out_ready;
    assign acc_br   = acc & in_is_branch;
    assign br_acc   = prefix_count(32'(acc_br), W);

    // A lane renames only if it writes a non-zero arch reg.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            wr[i] = in_uses_rd[i] && (in_rd[i] != '0);
        end
    end

    // In-order acceptance scan; stops at the first lane that does not fit.
    always_comb begin
        logic stop;
        int   rob_c;
        int   fl_c;
        int   sq_c;
        int   br_c;
        int   br_room;
        int   bank_c [NBANK];
        acc     = '0;
        stop    = !reset || flush || halt_seen || !can_take;
        rob_c   = 0;
        fl_c    = 0;
        sq_c    = 0;
        br_c    = 0;
        br_room = MAX_CKPT - int'(inflight_q);
        for (int b = 0; b < NBANK; b++) bank_c[b] = 0;
        for (int i = 0; i < W; i++) begin
            if (!stop) begin
                if (i >= int'(in_count)) begin
                    stop = 1'b1;
                end else if (rob_c + 1 > int'(rob_free)
                    || fl_c + int'(wr[i]) > int'(fl_free)
                    || sq_c + int'(in_is_store[i]) > int'(sq_free)
                    || bank_c[in_bank[i]] + 1
                       > int'(bank_free[in_bank[i]])
                    || br_c + int'(in_is_branch[i]) > br_room) begin
                    stop = 1'b1;
                end else begin
                    acc[i] = 1'b1;
                    rob_c  = rob_c + 1;
                    fl_c   = fl_c + int'(wr[i]);
                    sq_c   = sq_c + int'(in_is_store[i]);
                    br_c   = br_c + int'(in_is_branch[i]);
                    bank_c[in_bank[i]] = bank_c[in_bank[i]] + 1;
                    if (in_halt[i]) stop = 1'b1;
                end
            end
        end
    end

    // k-th accepted rd-writer takes the k-th freelist grant.
    always_comb begin
        int unsigned k;
        pdest = '0;
        for (int i = 0; i < W; i++) begin
            k = prefix_count(32'(wr), i);
            for (int t = 0; t < W; t++) begin
                if (acc[i] && wr[i] && k == t) pdest[i] = fl_tag[t];
            end
        end
    end

    rename_forward_net #(
        .W      (W),
        .ARCH_W (ARCH_W),
        .TAG_W  (TAG_W)
    ) u_fwd (
        .rs1        (in_rs1),
        .rs2        (in_rs2),
        .rd         (in_rd),
        .wr         (wr),
        .uses_rs2   (in_uses_rs2),
        .pdest      (pdest),
        .mt_rs1_tag (mt_rs1_tag),
        .mt_rs2_tag (mt_rs2_tag),
        .mt_told    (mt_told),
        .mt_rs1_rdy (mt_rs1_rdy),
        .mt_rs2_rdy (mt_rs2_rdy),
        .src1       (f_src1),
        .src2       (f_src2),
        .told       (f_told),
        .src1_rdy   (f_src1_rdy),
        .src2_rdy   (f_src2_rdy)
    );

    // Map-table writes, freelist pop and the next output group.
    always_comb begin
        mt_wr_valid  = acc & wr;
        mt_wr_addr   = '0;
        mt_wr_tag    = pdest;
        accept_count = CW'(prefix_count(32'(acc), W));
        fl_pop       = CW'(prefix_count(32'(acc & wr), W));
        lane_d       = '0;
        for (int i = 0; i < W; i++) begin
            if (mt_wr_valid[i]) mt_wr_addr[i] = in_rd[i];
            if (acc[i]) begin
                lane_d[i].valid    = 1'b1;
                lane_d[i].bank     = in_bank[i];
                lane_d[i].pdest    = pdest[i];
                lane_d[i].told     = wr[i] ? f_told[i] : '0;
                lane_d[i].src1     = f_src1[i];
                lane_d[i].src1_rdy = f_src1_rdy[i];
                lane_d[i].src2     = f_src2[i];
                lane_d[i].src2_rdy = f_src2_rdy[i];
                lane_d[i].rob_idx  = rob_alloc_idx[i];
                lane_d[i].pc       = in_pc[i];
                lane_d[i].halt     = in_halt[i];
                if (in_is_branch[i]) begin
                    lane_d[i].ckpt = CKPT_ID_T'(int'(ckpt_ptr)
                        + int'(prefix_count(32'(acc_br), i)));
                end
            end
        end
    end

    // Saturating in-flight checkpoint count.
    always_comb begin
        inflight_raw = int'(inflight_q) + int'(br_acc)
                     - int'(br_resolve_cnt);
        if (inflight_raw < 0) begin
            inflight_d = '0;
        end else if (inflight_raw > MAX_CKPT) begin
            inflight_d = KW'(MAX_CKPT);
        end else begin
            inflight_d = KW'(inflight_raw);
        end
    end

    // Output group, checkpoint state and halt flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            lane_q     <= '0;
            inflight_q <= '0;
            ckpt_ptr   <= '0;
            halt_seen  <= 1'b0;
        end else if (flush) begin
            valid_q    <= 1'b0;
            lane_q     <= '0;
            inflight_q <= '0;
            halt_seen  <= 1'b0;
        end else begin
            assert (inflight_raw >= 0);
            if (can_take) begin
                valid_q <= |acc;
                lane_q  <= lane_d;
            end
            inflight_q <= inflight_d;
            ckpt_ptr   <= ckpt_ptr + CKPT_ID_T'(br_acc);
            if (|(acc & in_halt)) halt_seen <= 1'b1;
        end
    end

    // Unpack the registered group onto the output ports.
    always_comb begin
        out_valid     = valid_q;
        ckpt_inflight = inflight_q;
        for (int i = 0; i < W; i++) begin
            out_lane_valid[i] = lane_q[i].valid;
            out_bank[i]       = lane_q[i].bank;
            out_pdest[i]      = lane_q[i].pdest;
            out_told[i]       = lane_q[i].told;
            out_src1[i]       = lane_q[i].src1;
            out_src2[i]       = lane_q[i].src2;
            out_src1_rdy[i]   = lane_q[i].src1_rdy;
            out_src2_rdy[i]   = lane_q[i].src2_rdy;
            out_rob_idx[i]    = lane_q[i].rob_idx;
            out_ckpt[i]       = lane_q[i].ckpt;
            out_pc[i]         = lane_q[i].pc;
            out_halt[i]       = lane_q[i].halt;
        end
    end

endmodule
